// File: rtl/sha256_round_ctrl_pkg.sv
// rtl/sha256_round_ctrl_pkg.sv - shared constants, state encoding and helpers for the SHA-256 round sequencer
package sha256_round_ctrl_pkg;

    // Compression rounds per 512-bit block.
    localparam int ROUNDS      = 64;
    // Width of the round counter and of round_idx.
    localparam int CNT_W       = 6;
    // Rounds 0..SCHED_WORDS-1 consume raw message words; later rounds use expanded words.
    localparam int SCHED_WORDS = 16;

    // Initial hash value. These are the default values of the H-bank register
    // instances, which h_init drives back to this state.
    localparam logic [31:0] H0 = 32'h6a09e667;
    localparam logic [31:0] H1 = 32'hbb67ae85;
    localparam logic [31:0] H2 = 32'h3c6ef372;
    localparam logic [31:0] H3 = 32'ha54ff53a;
    localparam logic [31:0] H4 = 32'h510e527f;
    localparam logic [31:0] H5 = 32'h9b05688c;
    localparam logic [31:0] H6 = 32'h1f83d9ab;
    localparam logic [31:0] H7 = 32'h5be0cd19;
    localparam logic [255:0] IV = {H0, H1, H2, H3, H4, H5, H6, H7};

    // Sequencer states, one per datapath phase.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_ROUND  = 3'd3,
        ST_UPDATE = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // True when round t takes its W[t] from the message expansion rather than the raw block.
    function automatic logic is_sched_round(input logic [CNT_W-1:0] idx);
        return idx >= CNT_W'(SCHED_WORDS);
    endfunction

endpackage

// File: rtl/sha256_round_counter.sv
// rtl/sha256_round_counter.sv - round counter with sync clear, enable and terminal-count flag
module sha256_round_counter #(
    parameter int CNT_W  = 6,
    parameter int TC_VAL = 63
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    // The count stops at TC_VAL so it never wraps; the controller leaves ROUND on tc.
    assign tc = (cnt == CNT_W'(TC_VAL));

    // Clear wins over enable; the value is held whenever not enabled.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sha256_round_ctrl.sv
// rtl/sha256_round_ctrl.sv - SHA-256 compression sequencer between message buffer and hash datapath
module sha256_round_ctrl
    import sha256_round_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             blk_valid,
    input  logic             blk_first,
    input  logic             blk_last,
    input  logic             abort,
    output logic             blk_ready,
    output logic             h_init,
    output logic             w_load,
    output logic             work_load,
    output logic             round_en,
    output logic [CNT_W-1:0] round_idx,
    output logic             w_sel,
    output logic             h_update,
    output logic             busy,
    output logic             digest_valid
);

    state_t           state;
    state_t           state_n;
    logic             last_q;
    logic [CNT_W-1:0] cnt;
    logic             cnt_tc;
    logic             cnt_clear;
    logic             cnt_en;
    logic             xfer;
    logic             abort_busy;
    logic [CNT_W-1:0] cnt_inc;

    // Blocks are only taken in IDLE, so blk_ready (high only in IDLE) is implied here.
    assign xfer       = (state == ST_IDLE) && blk_valid;
    // abort has no effect in IDLE, which lets a concurrent transfer through.
    assign abort_busy = abort && (state != ST_IDLE);

    // Counter restarts at 0 for the first round and is zeroed on abort.
    assign cnt_clear = (state == ST_LOAD) || abort_busy;
    assign cnt_en    = (state == ST_ROUND);
    assign cnt_inc   = cnt + CNT_W'(1);

    // round_idx is the counter flop itself, so it holds its last value outside ROUND.
    assign round_idx = cnt;

    sha256_round_counter #(
        .CNT_W  (CNT_W),
        .TC_VAL (ROUNDS - 1)
    ) u_round_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .en    (cnt_en),
        .cnt   (cnt),
        .tc    (cnt_tc)
    );

    // Next-state decode; abort outside IDLE overrides the normal sequence.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (xfer) state_n = blk_first ? ST_INIT : ST_LOAD;
            ST_INIT:   state_n = ST_LOAD;
            ST_LOAD:   state_n = ST_ROUND;
            ST_ROUND:  if (cnt_tc) state_n = ST_UPDATE;
            ST_UPDATE: state_n = last_q ? ST_DONE : ST_IDLE;
            ST_DONE:   state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
        if (abort_busy) begin
            state_n = ST_IDLE;
        end
    end

    // State and output flops; outputs are decoded from the next state so every strobe,
    // h_init in particular, comes straight out of a register with no glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            last_q       <= 1'b0;
            blk_ready    <= 1'b1;
            h_init       <= 1'b0;
            w_load       <= 1'b0;
            work_load    <= 1'b0;
            round_en     <= 1'b0;
            w_sel        <= 1'b0;
            h_update     <= 1'b0;
            busy         <= 1'b0;
            digest_valid <= 1'b0;
        end else begin
            state <= state_n;
            if (xfer) begin
                last_q <= blk_last;
            end
            blk_ready    <= (state_n == ST_IDLE);
            h_init       <= (state_n == ST_INIT);
            w_load       <= (state_n == ST_LOAD);
            work_load    <= (state_n == ST_LOAD);
            round_en     <= (state_n == ST_ROUND);
            // Round 0 always follows LOAD and uses a raw word; later rounds look at the
            // index the counter is about to present.
            w_sel        <= (state_n == ST_ROUND) && (state == ST_ROUND) && is_sched_round(cnt_inc);
            h_update     <= (state_n == ST_UPDATE);
            busy         <= (state_n != ST_IDLE);
            digest_valid <= (state_n == ST_DONE);
        end
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb/tb_sha256_round_ctrl.sv - scoreboard bench for the SHA-256 round sequencer
module tb_sha256_round_ctrl;
    import sha256_round_ctrl_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             blk_valid;
    logic             blk_first;
    logic             blk_last;
    logic             abort;
    logic             blk_ready;
    logic             h_init;
    logic             w_load;
    logic             work_load;
    logic             round_en;
    logic [CNT_W-1:0] round_idx;
    logic             w_sel;
    logic             h_update;
    logic             busy;
    logic             digest_valid;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    typedef enum int {EV_XFER, EV_HINIT, EV_LOAD, EV_R0, EV_WSEL, EV_R63, EV_UPD, EV_DIG} ev_t;
    typedef struct {
        ev_t kind;
        int  cyc;
    } exp_t;

    exp_t sb[$];

    sha256_round_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .blk_valid    (blk_valid),
        .blk_first    (blk_first),
        .blk_last     (blk_last),
        .abort        (abort),
        .blk_ready    (blk_ready),
        .h_init       (h_init),
        .w_load       (w_load),
        .work_load    (work_load),
        .round_en     (round_en),
        .round_idx    (round_idx),
        .w_sel        (w_sel),
        .h_update     (h_update),
        .busy         (busy),
        .digest_valid (digest_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s @%0d: got %0h required %0h", nm, cyc, act, exp_v);
        end
    endtask

    task automatic check_outs(input string nm);
        logic [14:0] act;
        act = {blk_ready, h_init, w_load, work_load, round_en, round_idx,
               w_sel, h_update, busy, digest_valid};
        check(nm, {17'd0, act}, 32'h0000_4000);
    endtask

    task automatic expect_ev(input ev_t k, input int c);
        exp_t e;
        e.kind = k;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // Expected event timeline for one block transferred in cycle c.
    task automatic push_block(input int c, input bit first, input bit last);
        int o;
        o = first ? 1 : 0;
        expect_ev(EV_XFER, c);
        if (first) expect_ev(EV_HINIT, c + 1);
        expect_ev(EV_LOAD, c + 1 + o);
        expect_ev(EV_R0,   c + 2 + o);
        expect_ev(EV_WSEL, c + 18 + o);
        expect_ev(EV_R63,  c + 65 + o);
        expect_ev(EV_UPD,  c + 66 + o);
        if (last) expect_ev(EV_DIG, c + 67 + o);
    endtask

    task automatic see(input ev_t k);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL event %s @%0d: got unexpected event, required none", k.name(), cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                errors++;
                $display("FAIL event: got %s@%0d required %s@%0d", k.name(), cyc, e.kind.name(), e.cyc);
            end
        end
    endtask

    logic prev_en  = 1'b0;
    int   prev_idx = 0;

    // Monitor: samples mid-cycle, turns DUT strobes into events and checks invariants.
    always @(negedge clk) begin
        if (reset) begin
            prev_en = 1'b0;
        end else begin
            if (blk_valid && blk_ready) see(EV_XFER);
            if (h_init) see(EV_HINIT);
            if (w_load || work_load) begin
                check("w_load_eq_work_load", {31'd0, w_load}, {31'd0, work_load});
                see(EV_LOAD);
            end
            if (round_en) begin
                check("w_sel_vs_idx", {31'd0, w_sel}, {31'd0, (int'(round_idx) >= 16)});
                if (prev_en) check("round_idx_step", {26'd0, round_idx}, prev_idx + 1);
                if (round_idx == 0) see(EV_R0);
                if (round_idx == 16 && w_sel) see(EV_WSEL);
                if (round_idx == 63) see(EV_R63);
            end
            check("busy_vs_ready", {31'd0, busy}, {31'd0, ~blk_ready});
            if (h_update) see(EV_UPD);
            if (digest_valid) see(EV_DIG);
            prev_en  = round_en;
            prev_idx = int'(round_idx);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) step();
    endtask

    int c;
    int d;

    initial begin
        reset     = 1'b1;
        blk_valid = 1'b0;
        blk_first = 1'b0;
        blk_last  = 1'b0;
        abort     = 1'b0;
        repeat (3) step();
        check_outs("reset_vals");
        reset = 1'b0;

        // 1: single-block message
        c = cyc;
        push_block(c, 1, 1);
        blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b1;
        step();
        blk_valid = 1'b0;
        check("t1_hinit", {31'd0, h_init}, 1);
        wait_to(c + 68);
        check("t1_ready_at_done", {31'd0, blk_ready}, 0);
        check("t1_digest", {31'd0, digest_valid}, 1);
        wait_to(c + 69);
        check("t1_ready_back", {31'd0, blk_ready}, 1);

        // 2: two-block message
        c = cyc;
        push_block(c, 1, 0);
        blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b0;
        step();
        blk_valid = 1'b0;
        wait_to(c + 68);
        check("t2_no_digest_blk1", {31'd0, digest_valid}, 0);
        check("t2_ready_blk2", {31'd0, blk_ready}, 1);
        push_block(c + 68, 0, 1);
        blk_valid = 1'b1; blk_first = 1'b0; blk_last = 1'b1;
        step();
        blk_valid = 1'b0;
        check("t2_no_hinit", {31'd0, h_init}, 0);
        wait_to(c + 136);
        check("t2_idle", {31'd0, blk_ready}, 1);

        // 3: abort mid-round, then restart with a first block
        c = cyc;
        expect_ev(EV_XFER, c);
        expect_ev(EV_HINIT, c + 1);
        expect_ev(EV_LOAD, c + 2);
        expect_ev(EV_R0, c + 3);
        expect_ev(EV_WSEL, c + 19);
        blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b1;
        step();
        blk_valid = 1'b0;
        wait_to(c + 33);
        check("t3_idx_before_abort", {26'd0, round_idx}, 30);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t3_round_en_off", {31'd0, round_en}, 0);
        check("t3_ready", {31'd0, blk_ready}, 1);
        check("t3_busy", {31'd0, busy}, 0);
        wait_to(c + 40);
        d = cyc;
        push_block(d, 1, 1);
        blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b1;
        step();
        blk_valid = 1'b0;
        wait_to(d + 69);

        // 4: blk_valid held for 150 cycles, last=0
        c = cyc;
        push_block(c, 1, 0);
        push_block(c + 68, 0, 0);
        push_block(c + 135, 0, 0);
        blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b0;
        step();
        blk_first = 1'b0;
        check("t4_ready_low_a", {31'd0, blk_ready}, 0);
        wait_to(c + 100);
        check("t4_ready_low_b", {31'd0, blk_ready}, 0);
        wait_to(c + 150);
        blk_valid = 1'b0;
        wait_to(c + 202);
        check("t4_idle", {31'd0, blk_ready}, 1);

        // 5: reset mid-round, then reset held with blk_valid
        c = cyc;
        expect_ev(EV_XFER, c);
        expect_ev(EV_HINIT, c + 1);
        expect_ev(EV_LOAD, c + 2);
        expect_ev(EV_R0, c + 3);
        blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b1;
        step();
        blk_valid = 1'b0;
        wait_to(c + 13);
        check("t5_idx_before_reset", {26'd0, round_idx}, 10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_outs("t5_reset_pulse");
        reset = 1'b1; blk_valid = 1'b1;
        repeat (3) step();
        check_outs("t5_reset_held");
        reset = 1'b0;
        d = cyc;
        push_block(d, 1, 1);
        step();
        blk_valid = 1'b0;
        wait_to(d + 69);

        // 6: abort with reset mid-round, then abort with a transfer in IDLE
        c = cyc;
        expect_ev(EV_XFER, c);
        expect_ev(EV_HINIT, c + 1);
        expect_ev(EV_LOAD, c + 2);
        expect_ev(EV_R0, c + 3);
        expect_ev(EV_WSEL, c + 19);
        blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b1;
        step();
        blk_valid = 1'b0;
        wait_to(c + 20);
        abort = 1'b1; reset = 1'b1;
        step();
        abort = 1'b0; reset = 1'b0;
        check_outs("t6_abort_reset");
        d = cyc;
        push_block(d, 1, 0);
        abort = 1'b1; blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b0;
        step();
        abort = 1'b0; blk_valid = 1'b0;
        check("t6_hinit_after_idle_abort", {31'd0, h_init}, 1);
        wait_to(d + 70);

        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
